// File: rtl/fir_coeff_load_ctrl_if.sv
// Bundles the coefficient-load request, the coefficient stream and the FIR/RAM control outputs.
// No logic and no latency: signals only.
// Backpressure is carried by oCoefReady; the master must hold iCoefValid/iCoefData until accepted.
interface fir_coeff_load_ctrl_if #(
  parameter int P_COEF_W = 16,
  parameter int P_ADDR_W = 6
);
  logic                iLoadReq;
  logic [P_ADDR_W-1:0] iNumOfCoeff;
  logic                iCoefValid;
  logic [P_COEF_W-1:0] iCoefData;
  logic                oCoefReady;
  logic                oEnSample_300k;
  logic                oCoeffiUpdateFlag;
  logic                oCsnRam;
  logic                oWrnRam;
  logic [P_ADDR_W-1:0] oAddrRam;
  logic [P_COEF_W-1:0] oWrDtRam;
  logic [P_ADDR_W-1:0] oNumOfCoeff;
  logic                oBusy;
  logic                oDone;
  logic                oErr;

  // Side that requests loads and streams coefficients.
  modport master (
    output iLoadReq, iNumOfCoeff, iCoefValid, iCoefData,
    input  oCoefReady, oEnSample_300k, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
    input  oAddrRam, oWrDtRam, oNumOfCoeff, oBusy, oDone, oErr
  );

  // The load controller itself.
  modport slave (
    input  iLoadReq, iNumOfCoeff, iCoefValid, iCoefData,
    output oCoefReady, oEnSample_300k, oCoeffiUpdateFlag, oCsnRam, oWrnRam,
    output oAddrRam, oWrDtRam, oNumOfCoeff, oBusy, oDone, oErr
  );
endinterface

// File: rtl/fir_coeff_load_ctrl.sv
// FIR coefficient load sequencer plus 300 kHz sample-enable generator.
// Latency: request -> LOAD next cycle; accepted word -> RAM write next cycle; last write -> DONE next cycle.
// Backpressure: oCoefReady drops once the requested word count is accepted; gaps in iCoefValid just stall.
module fir_coeff_load_ctrl #(
  parameter int P_NUM_TAPS   = 33,
  parameter int P_SAMPLE_DIV = 40,
  parameter int P_COEF_W     = 16,
  parameter int P_ADDR_W     = 6
) (
  input  logic                  iClk_12M,
  input  logic                  iRst,
  fir_coeff_load_ctrl_if.slave  bus
);

  localparam int                  CNT_W    = (P_SAMPLE_DIV > 1) ? $clog2(P_SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(P_SAMPLE_DIV - 1);
  // P_NUM_TAPS must be representable in P_ADDR_W bits for the range check to hold.
  localparam logic [P_ADDR_W-1:0] MAX_TAPS = P_ADDR_W'(P_NUM_TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [P_ADDR_W-1:0] num_q;      // count latched at request time
  logic [P_ADDR_W-1:0] idx_q;      // words accepted so far in this load
  logic [P_ADDR_W-1:0] idx_inc;
  logic [P_ADDR_W-1:0] addr_q;
  logic [P_ADDR_W-1:0] tap_q;      // tap count currently in use by the FIR
  logic [P_COEF_W-1:0] wdat_q;
  logic                en_q;
  logic                flag_q;
  logic                csn_q;
  logic                wrn_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                req_ok;
  logic                accept;
  logic                sample_hit;

  // Next sample-counter value: free-running wrap, restarted on the DONE cycle so
  // the first enable lands exactly P_SAMPLE_DIV cycles after DONE.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == DONE || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end
  end

  // The enable register is loaded from the next count so it lines up with the
  // counter sitting at its terminal value.
  assign sample_hit = (cnt_d == CNT_LAST);
  assign req_ok     = (bus.iNumOfCoeff != '0) && (bus.iNumOfCoeff <= MAX_TAPS);
  assign accept     = (state_q == LOAD) && bus.iCoefValid && ready_q;
  assign idx_inc    = idx_q + 1'b1;

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      tap_q   <= '0;
      wdat_q  <= '0;
      en_q    <= 1'b0;
      flag_q  <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      // Pulses and the write strobe default inactive every cycle.
      en_q   <= 1'b0;
      wrn_q  <= 1'b1;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (state_q == RUN) begin
            en_q <= sample_hit;
          end
          if (bus.iLoadReq) begin
            if (req_ok) begin
              // Old tap count stays live on oNumOfCoeff until the new DONE.
              state_q <= LOAD;
              num_q   <= bus.iNumOfCoeff;
              idx_q   <= '0;
              flag_q  <= 1'b1;
              csn_q   <= 1'b0;
              busy_q  <= 1'b1;
              ready_q <= 1'b1;
              en_q    <= 1'b0;
            end else begin
              // Rejected request: only the error pulse, nothing else moves.
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wrn_q   <= 1'b0;
            addr_q  <= idx_inc;
            wdat_q  <= bus.iCoefData;
            idx_q   <= idx_inc;
            ready_q <= (idx_inc < num_q);
          end else if (idx_q == num_q) begin
            // Reached on the cycle carrying the final write.
            state_q <= DONE;
            flag_q  <= 1'b0;
            done_q  <= 1'b1;
            tap_q   <= num_q;
          end
        end
        DONE: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.oCoefReady        = ready_q;
  assign bus.oEnSample_300k    = en_q;
  assign bus.oCoeffiUpdateFlag = flag_q;
  assign bus.oCsnRam           = csn_q;
  assign bus.oWrnRam           = wrn_q;
  assign bus.oAddrRam          = addr_q;
  assign bus.oWrDtRam          = wdat_q;
  assign bus.oNumOfCoeff       = tap_q;
  assign bus.oBusy             = busy_q;
  assign bus.oDone             = done_q;
  assign bus.oErr              = err_q;

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Bench for the FIR coefficient load sequencer.
// RAM writes are checked against a scoreboard filled when words are accepted.
// Each scenario task does its own inline comparisons.
module tb_fir_coeff_load_ctrl;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [21:0] sb_q[$];   // {addr, data} of expected RAM writes

  localparam logic [35:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 6'd0, 4'd0};

  fir_coeff_load_ctrl_if #(.P_COEF_W(16), .P_ADDR_W(6)) bus ();

  fir_coeff_load_ctrl #(
    .P_NUM_TAPS  (33),
    .P_SAMPLE_DIV(40),
    .P_COEF_W    (16),
    .P_ADDR_W    (6)
  ) dut (
    .iClk_12M(clk),
    .iRst    (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  initial begin
    #(84 * 40000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [35:0] outs();
    return {bus.oEnSample_300k, bus.oCoeffiUpdateFlag, bus.oCsnRam, bus.oWrnRam,
            bus.oAddrRam, bus.oWrDtRam, bus.oNumOfCoeff,
            bus.oCoefReady, bus.oBusy, bus.oDone, bus.oErr};
  endfunction

  // Every RAM write must match the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (bus.oWrnRam === 1'b0) begin
      logic [21:0] exp_w;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", bus.oAddrRam, bus.oWrDtRam);
      end else begin
        exp_w = sb_q.pop_front();
        if ({bus.oAddrRam, bus.oWrDtRam} !== exp_w || bus.oCsnRam !== 1'b0) begin
          errors++;
          $display("FAIL ram_write: got addr=%0d data=%h csn=%b, want addr=%0d data=%h csn=0",
                   bus.oAddrRam, bus.oWrDtRam, bus.oCsnRam, exp_w[21:16], exp_w[15:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iLoadReq = 1'b0; bus.iNumOfCoeff = '0; bus.iCoefValid = 1'b0; bus.iCoefData = '0;
    #100;
    checks++;
    if (outs() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h, want %h", outs(), RST_VEC);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.oEnSample_300k, bus.oCsnRam, bus.oWrnRam, bus.oNumOfCoeff, bus.oBusy} !== {1'b0, 1'b1, 1'b1, 6'd0, 1'b0}) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d: got en=%b csn=%b wrn=%b num=%0d busy=%b, want 0 1 1 0 0",
                 k, bus.oEnSample_300k, bus.oCsnRam, bus.oWrnRam, bus.oNumOfCoeff, bus.oBusy);
      end
    end
  endtask

  task automatic test_errors();
    int bad [3] = '{0, 40, 34};
    for (int i = 0; i < 3; i++) begin
      bus.iNumOfCoeff = 6'(bad[i]);
      bus.iLoadReq = 1'b1;
      tick();
      bus.iLoadReq = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.oErr, bus.oBusy, bus.oCsnRam, bus.oCoeffiUpdateFlag, bus.oCoefReady} !== 5'b10100) begin
        errors++;
        $display("FAIL reject_%0d: got err=%b busy=%b csn=%b flag=%b rdy=%b, want 1 0 1 0 0",
                 bad[i], bus.oErr, bus.oBusy, bus.oCsnRam, bus.oCoeffiUpdateFlag, bus.oCoefReady);
      end
      @(negedge clk);
      checks++;
      if ({bus.oErr, bus.oBusy, bus.oCsnRam} !== 3'b001) begin
        errors++;
        $display("FAIL reject_after_%0d: got err=%b busy=%b csn=%b, want 0 0 1",
                 bad[i], bus.oErr, bus.oBusy, bus.oCsnRam);
      end
    end
  endtask

  // Runs one accepted load and ends at the falling edge of the DONE cycle.
  task automatic run_load(input int n, input bit toggle, input int base, input int step,
                          input int req_it, input logic [5:0] old_num);
    int sent = 0;
    int it = 0;
    logic [15:0] d;
    bus.iNumOfCoeff = 6'(n);
    bus.iLoadReq = 1'b1;
    tick();
    bus.iLoadReq = 1'b0;
    while (sent < n && it < 4 * n + 10) begin
      bus.iLoadReq    = (it == req_it);
      bus.iNumOfCoeff = (it == req_it) ? 6'd3 : 6'(n);
      bus.iCoefValid  = toggle ? ((it % 2) == 0) : 1'b1;
      d = 16'(base + sent * step);
      bus.iCoefData   = d;
      @(negedge clk);
      checks++;
      if ({bus.oCoeffiUpdateFlag, bus.oBusy, bus.oErr, bus.oEnSample_300k, bus.oNumOfCoeff} !== {3'b110, 1'b0, old_num}) begin
        errors++;
        $display("FAIL load_status it %0d: got flag=%b busy=%b err=%b en=%b num=%0d, want 1 1 0 0 %0d",
                 it, bus.oCoeffiUpdateFlag, bus.oBusy, bus.oErr, bus.oEnSample_300k, bus.oNumOfCoeff, old_num);
      end
      if (bus.iCoefValid && bus.oCoefReady) begin
        sb_q.push_back({6'(sent + 1), d});
        sent++;
      end
      tick();
      it++;
    end
    bus.iLoadReq = 1'b0;
    bus.iCoefValid = 1'b1;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d words, want %0d", sent, n);
    end
    @(negedge clk);
    checks++;
    if ({bus.oCoefReady, bus.oCoeffiUpdateFlag, bus.oErr, bus.oDone} !== 4'b0100) begin
      errors++;
      $display("FAIL after_last_accept: got rdy=%b flag=%b err=%b done=%b, want 0 1 0 0",
               bus.oCoefReady, bus.oCoeffiUpdateFlag, bus.oErr, bus.oDone);
    end
    @(negedge clk);
    checks++;
    if ({bus.oDone, bus.oBusy, bus.oCoeffiUpdateFlag, bus.oCsnRam, bus.oNumOfCoeff} !== {4'b1100, 6'(n)}) begin
      errors++;
      $display("FAIL done_cycle: got done=%b busy=%b flag=%b csn=%b num=%0d, want 1 1 0 0 %0d",
               bus.oDone, bus.oBusy, bus.oCoeffiUpdateFlag, bus.oCsnRam, bus.oNumOfCoeff, n);
    end
    bus.iCoefValid = 1'b0;
  endtask

  task automatic check_run_enables(input int cycles, input logic [5:0] num);
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.oEnSample_300k, bus.oBusy, bus.oDone, bus.oCsnRam, bus.oNumOfCoeff} !== {(k % 40) == 0, 3'b000, num}) begin
        errors++;
        $display("FAIL run_enable k=%0d: got en=%b busy=%b done=%b csn=%b num=%0d, want en=%b 0 0 0 %0d",
                 k, bus.oEnSample_300k, bus.oBusy, bus.oDone, bus.oCsnRam, bus.oNumOfCoeff, (k % 40) == 0, num);
      end
    end
  endtask

  task automatic test_full_load();
    run_load(33, 1'b0, 1, 1, -1, 6'd0);
    check_run_enables(120, 6'd33);
  endtask

  task automatic test_reload_from_run();
    run_load(10, 1'b0, 16'hFF00, -257, 3, 6'd33);
    check_run_enables(45, 6'd10);
  endtask

  task automatic test_toggle_valid();
    run_load(5, 1'b1, 16'h7FF0, 5, -1, 6'd10);
    check_run_enables(5, 6'd5);
  endtask

  task automatic test_reset_mid_load();
    int wr = 0;
    int sent = 0;
    bit hit = 1'b0;
    logic [15:0] d;
    bus.iNumOfCoeff = 6'd20;
    bus.iLoadReq = 1'b1;
    tick();
    bus.iLoadReq = 1'b0;
    for (int it = 0; it < 60 && !hit; it++) begin
      d = 16'h8000 | 16'(sent);
      bus.iCoefValid = 1'b1;
      bus.iCoefData  = d;
      @(negedge clk);
      if (bus.oWrnRam === 1'b0) wr++;
      if (bus.oCoefReady) begin
        sb_q.push_back({6'(sent + 1), d});
        sent++;
      end
      if (wr == 7) begin
        hit = 1'b1;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outs() !== RST_VEC) begin
          errors++;
          $display("FAIL mid_load_reset: got %h, want %h", outs(), RST_VEC);
        end
        sb_q.delete();
      end else begin
        tick();
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_load_seventh_write: saw %0d writes, want 7", wr);
    end
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.oCoefReady, bus.oCsnRam, bus.oBusy, bus.oNumOfCoeff, bus.oCoeffiUpdateFlag} !== {3'b010, 6'd0, 1'b0}) begin
        errors++;
        $display("FAIL post_reset_idle k=%0d: got rdy=%b csn=%b busy=%b num=%0d flag=%b, want 0 1 0 0 0",
                 k, bus.oCoefReady, bus.oCsnRam, bus.oBusy, bus.oNumOfCoeff, bus.oCoeffiUpdateFlag);
      end
    end
    bus.iCoefValid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_errors();
    test_full_load();
    test_reload_from_run();
    test_toggle_valid();
    test_reset_mid_load();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d expected writes never seen, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
